// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for instruction fetch and MEM-stage data accesses.
// Data wins by default; a fetch starvation guard and a sticky RAM-timeout error are included.
module mem_arbiter #(
  parameter int TIMEOUT    = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_store,
  input  logic [31:0] ram_load,
  input  logic        ram_ready,
  output logic        ram_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int SC_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {IDLE, DSERVE, ISERVE, RESP, ERROR} state_t;

  state_t          state;
  logic [WD_W-1:0] wd;
  logic [SC_W-1:0] starve_cnt;
  logic            wr_q;

  logic dreq, starved;
  assign dreq    = dREN | dWEN;
  assign starved = (starve_cnt == SC_W'(STARVE_MAX)) && iREN;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      wd         <= '0;
      starve_cnt <= '0;
      wr_q       <= 1'b0;
      iload      <= '0;
      dload      <= '0;
      ihit       <= 1'b0;
      dhit       <= 1'b0;
      ram_ren    <= 1'b0;
      ram_wen    <= 1'b0;
      ram_addr   <= '0;
      ram_store  <= '0;
      ram_err    <= 1'b0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      case (state)
        IDLE: begin
          if (dreq && !starved) begin
            state     <= DSERVE;
            wd        <= '0;
            wr_q      <= dWEN;
            ram_wen   <= dWEN;
            ram_ren   <= ~dWEN;
            ram_addr  <= daddr;
            ram_store <= dstore;
            if (iREN && starve_cnt != SC_W'(STARVE_MAX))
              starve_cnt <= starve_cnt + 1'b1;
          end else if (iREN) begin
            state      <= ISERVE;
            wd         <= '0;
            wr_q       <= 1'b0;
            ram_ren    <= 1'b1;
            ram_wen    <= 1'b0;
            ram_addr   <= iaddr;
            starve_cnt <= '0;
          end
        end
        DSERVE, ISERVE: begin
          if (ram_ready) begin
            state   <= RESP;
            ram_ren <= 1'b0;
            ram_wen <= 1'b0;
            if (state == ISERVE) begin
              iload <= ram_load;
              ihit  <= 1'b1;
            end else begin
              dhit <= 1'b1;
              if (!wr_q) dload <= ram_load;
            end
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            // Last allowed wait cycle ended without ready: give up for good.
            state   <= ERROR;
            ram_ren <= 1'b0;
            ram_wen <= 1'b0;
            ram_err <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        // Requester still shows the just-served request here, so no grant.
        RESP:    state <= IDLE;
        ERROR:   state <= ERROR;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch, priority, starvation guard,
// timeout boundary, RAM timeout error and reset mid-access.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, iload, dload;
  logic        ihit, dhit, ram_ren, ram_wen, ram_ready, ram_err;
  logic [31:0] ram_addr, ram_store, ram_load;

  mem_arbiter #(.TIMEOUT(8), .STARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dhit(dhit),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready),
    .ram_err(ram_err)
  );

  always #5 CLK = ~CLK;

  // RAM model: ready after ws wait states of continuous strobe.
  int          ws = 0;
  bit          rdy_en = 1'b1;
  int          wcnt = 0;
  logic [31:0] rdata = '0;
  always @(posedge CLK) wcnt <= (ram_ren | ram_wen) ? wcnt + 1 : 0;
  assign ram_ready = rdy_en && (ram_ren | ram_wen) && (wcnt == ws);
  assign ram_load  = rdata;

  bit both_hit = 1'b0;
  always @(negedge CLK) if (ihit && dhit) both_hit = 1'b1;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  logic [31:0] s_addr, s_store;
  logic        s_wen;

  task automatic wait_hit(output int n, output bit gi, output bit gd, output int sc);
    n = 0; sc = 0; gi = 1'b0; gd = 1'b0;
    while (!gi && !gd && n < 40) begin
      step();
      n++;
      if (ram_ren | ram_wen) begin
        sc++;
        s_addr  = ram_addr;
        s_wen   = ram_wen;
        s_store = ram_store;
      end
      gi = ihit;
      gd = dhit;
    end
  endtask

  int n, sc, hits, act;
  bit gi, gd, saw;
  bit seq[6];
  int tc[6];

  initial begin
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    step(); step();
    RST = 1'b0;

    // reset and idle
    act = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ram_ren | ram_wen | ihit | dhit | ram_err) act++;
    end
    chk("idle_activity", act, 0);
    chk("rst_iload", iload, 32'h0);
    chk("rst_dload", dload, 32'h0);
    chk("rst_addr", ram_addr, 32'h0);
    chk("rst_store", ram_store, 32'h0);

    // single fetch, 2 wait states
    iREN = 1; iaddr = 32'h40; ws = 2; rdata = 32'h8C010004;
    wait_hit(n, gi, gd, sc);
    iREN = 0;
    chk("fetch_ihit", gi, 1);
    chk("fetch_no_dhit", gd, 0);
    chk("fetch_strobes", sc, 3);
    chk("fetch_addr", s_addr, 32'h40);
    chk("fetch_iload", iload, 32'h8C010004);
    step();
    chk("fetch_pulse", ihit, 0);
    chk("iload_held", iload, 32'h8C010004);

    // simultaneous fetch and write, zero wait
    step();
    iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    ws = 0; rdata = 32'h11112222;
    wait_hit(n, gi, gd, sc);
    dWEN = 0;
    chk("prio_dhit", gd, 1);
    chk("prio_latency", n, 2);
    chk("prio_wen", s_wen, 1);
    chk("prio_addr", s_addr, 32'h100);
    chk("prio_store", s_store, 32'hDEADBEEF);
    chk("write_dload_kept", dload, 32'h0);
    wait_hit(n, gi, gd, sc);
    iREN = 0;
    chk("prio_then_ihit", gi, 1);
    chk("prio_iload", iload, 32'h11112222);

    // starvation guard
    step();
    iREN = 1; iaddr = 32'h48; dREN = 1; daddr = 32'h200; rdata = 32'h1234ABCD;
    hits = 0;
    for (int c = 0; c < 80 && hits < 6; c++) begin
      step();
      if (dhit || ihit) begin
        seq[hits] = ihit;
        tc[hits]  = c;
        hits++;
        if (ihit) iREN = 0;
      end
    end
    dREN = 0;
    chk("starve_hits", hits, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("starve_seq%0d", i), seq[i], (i == 4) ? 1 : 0);
    chk("throughput", tc[1] - tc[0], 3);
    chk("read_dload", dload, 32'h1234ABCD);
    step(); step();

    // timeout boundary: ready in the 8th strobe cycle still completes
    ws = 7; dREN = 1; daddr = 32'h300; rdata = 32'h0BADF00D;
    wait_hit(n, gi, gd, sc);
    dREN = 0;
    chk("bound_dhit", gd, 1);
    chk("bound_strobes", sc, 8);
    chk("bound_err", ram_err, 0);
    chk("bound_dload", dload, 32'h0BADF00D);
    step(); step();

    // RAM never ready -> sticky error
    rdy_en = 0; dREN = 1; daddr = 32'h304;
    sc = 0; saw = 0;
    for (int c = 0; c < 30 && !ram_err; c++) begin
      step();
      if (ram_ren | ram_wen) sc++;
      if (dhit) saw = 1;
    end
    chk("to_err", ram_err, 1);
    chk("to_strobes", sc, 8);
    chk("to_no_dhit", saw, 0);
    chk("to_strobe_low", ram_ren | ram_wen, 0);
    step(); step();
    chk("err_sticky", ram_err, 1);
    chk("err_no_dhit", dhit, 0);
    dREN = 0; rdy_en = 1;
    RST = 1; step(); RST = 0;
    chk("rst_clears_err", ram_err, 0);
    chk("rst_dload_zero", dload, 32'h0);

    // reset during the 2nd wait cycle of a read
    step();
    ws = 5; dREN = 1; daddr = 32'h308; rdata = 32'hCAFEF00D;
    step(); step();
    chk("mid_strobe", ram_ren, 1);
    RST = 1; step(); RST = 0; dREN = 0;
    chk("mid_strobe_drop", ram_ren | ram_wen, 0);
    saw = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (dhit) saw = 1;
    end
    chk("mid_no_dhit", saw, 0);
    chk("mid_dload", dload, 32'h0);
    ws = 0; dREN = 1; daddr = 32'h30C; rdata = 32'h55AA55AA;
    wait_hit(n, gi, gd, sc);
    dREN = 0;
    chk("after_rst_dhit", gd, 1);
    chk("after_rst_latency", n, 2);
    chk("after_rst_dload", dload, 32'h55AA55AA);
    step(); step();

    chk("never_both_hits", both_hit, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
